// File: rtl/problema1_pio_pkg.sv
// Shared register map for the problema1 PIO ports.
package problema1_pio_pkg;

    localparam logic [1:0] ADDR_DATA  = 2'd0;
    localparam logic [1:0] ADDR_SET   = 2'd1;
    localparam logic [1:0] ADDR_CLR   = 2'd2;
    localparam logic [1:0] ADDR_PULSE = 2'd3;

    localparam int BUSY_BIT = 31;

endpackage

// File: rtl/problema1_pulse_timer.sv
// Pulse timer: holds an inversion mask for PULSE_CYCLES clocks after a load,
// then clears it. A zero-mask load cancels a running pulse.
module problema1_pulse_timer #(
    parameter int WIDTH        = 4,
    parameter int CNT_W        = 26,
    parameter int PULSE_CYCLES = 25000000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] mask,
    output logic [WIDTH-1:0] pulse_mask,
    output logic [CNT_W-1:0] count,
    output logic             busy
);

    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(PULSE_CYCLES);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pulse_mask <= '0;
            count      <= '0;
        end else if (load) begin
            if (mask != '0) begin
                pulse_mask <= mask;
                count      <= LOAD_VAL;
            end else begin
                pulse_mask <= '0;
                count      <= '0;
            end
        end else if (count != '0) begin
            // mask drops on the same edge the count reaches zero
            if (count == ONE)
                pulse_mask <= '0;
            count <= count - ONE;
        end
    end

    assign busy = (count != '0);

endmodule

// File: rtl/problema1_outport_pulse.sv
// Avalon-MM output port with atomic set/clear and a timed bit-inversion pulse.
// out_port is the XOR of two flops, so there is no bus-to-pin combinational path.
module problema1_outport_pulse
    import problema1_pio_pkg::*;
#(
    parameter int               WIDTH        = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE  = '0,
    parameter int               PULSE_CYCLES = 25000000,
    parameter int               CNT_W        = 26
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    logic [WIDTH-1:0] data_reg;
    logic [WIDTH-1:0] wr_bits;
    logic [WIDTH-1:0] pulse_mask;
    logic [CNT_W-1:0] count;
    logic             busy;
    logic             wr_en;
    logic             pulse_load;
    logic [31:0]      rd_next;
    logic             unused_wdata;

    assign wr_en        = chipselect && !write_n;
    assign wr_bits      = writedata[WIDTH-1:0];
    assign pulse_load   = wr_en && (address == ADDR_PULSE);
    assign unused_wdata = ^writedata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_reg <= RESET_VALUE;
        end else if (wr_en) begin
            case (address)
                ADDR_DATA: data_reg <= wr_bits;
                ADDR_SET:  data_reg <= data_reg | wr_bits;
                ADDR_CLR:  data_reg <= data_reg & ~wr_bits;
                default:   data_reg <= data_reg;
            endcase
        end
    end

    problema1_pulse_timer #(
        .WIDTH        (WIDTH),
        .CNT_W        (CNT_W),
        .PULSE_CYCLES (PULSE_CYCLES)
    ) u_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (pulse_load),
        .mask       (wr_bits),
        .pulse_mask (pulse_mask),
        .count      (count),
        .busy       (busy)
    );

    assign out_port = data_reg ^ pulse_mask;

    always_comb begin
        rd_next = '0;
        case (address)
            ADDR_DATA: rd_next[WIDTH-1:0] = data_reg;
            ADDR_SET:  rd_next[WIDTH-1:0] = out_port;
            ADDR_CLR:  rd_next[WIDTH-1:0] = pulse_mask;
            default: begin
                rd_next[BUSY_BIT]  = busy;
                rd_next[CNT_W-1:0] = count;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            readdata <= '0;
        else
            readdata <= rd_next;
    end

endmodule

// File: tb/tb_problema1_outport_pulse.sv
// Self-checking bench: a register-map model pushes expected out_port/readdata
// per cycle into a scoreboard that is popped after each clock edge.
module tb_problema1_outport_pulse;

    localparam int WIDTH = 4;
    localparam int PC    = 5;
    localparam int CNT_W = 26;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic [3:0]  out_port;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]  out;
        logic [31:0] rd;
    } exp_t;
    exp_t sb[$];

    logic [3:0] m_data = 4'h0;
    logic [3:0] m_mask = 4'h0;
    int         m_cnt  = 0;

    problema1_outport_pulse #(
        .WIDTH        (WIDTH),
        .RESET_VALUE  (4'h0),
        .PULSE_CYCLES (PC),
        .CNT_W        (CNT_W)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // One bus cycle: drive, predict, clock, compare.
    task automatic cycle(input logic [1:0] a, input logic wr, input logic [31:0] wd);
        exp_t       e;
        logic [31:0] rd;
        logic [3:0]  bits;
        logic        pulse_wr;
        address    = a;
        chipselect = wr ? 1'b1 : $urandom_range(0, 1) == 1;
        write_n    = ~wr;
        writedata  = wd;
        bits       = wd[3:0];
        rd         = '0;
        case (a)
            2'd0: rd[3:0] = m_data;
            2'd1: rd[3:0] = m_data ^ m_mask;
            2'd2: rd[3:0] = m_mask;
            default: begin
                rd[31]      = (m_cnt != 0);
                rd[25:0]    = 26'(m_cnt);
            end
        endcase
        pulse_wr = wr && (a == 2'd3);
        if (wr) begin
            case (a)
                2'd0: m_data = bits;
                2'd1: m_data = m_data | bits;
                2'd2: m_data = m_data & ~bits;
                default: begin
                    m_mask = bits;
                    m_cnt  = (bits != 0) ? PC : 0;
                end
            endcase
        end
        if (!pulse_wr && m_cnt != 0) begin
            m_cnt--;
            if (m_cnt == 0) m_mask = 4'h0;
        end
        e.out = m_data ^ m_mask;
        e.rd  = rd;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("out_port", {28'h0, out_port}, {28'h0, e.out});
        check("readdata", readdata, e.rd);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    initial begin
        int inv;
        #1;
        check("rst_out_port", {28'h0, out_port}, 32'h0);
        check("rst_readdata", readdata, 32'h0);
        #11 reset_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: DATA write and readback latency
        cycle(2'd0, 1'b1, 32'hFFFF_FFFA);
        check("t1_out", {28'h0, out_port}, 32'hA);
        cycle(2'd0, 1'b0, 32'h0);
        check("t1_read0", readdata, 32'h0000_000A);

        // 2: SET / CLEAR with junk upper bits
        cycle(2'd1, 1'b1, 32'hFFFF_FFF1);
        check("t2_set", {28'h0, out_port}, 32'hB);
        cycle(2'd2, 1'b1, 32'hFFFF_FFF8);
        check("t2_clr", {28'h0, out_port}, 32'h3);

        // 3: pulse 0x5 over data 0x3 lasts exactly PC cycles
        cycle(2'd0, 1'b1, 32'h3);
        cycle(2'd3, 1'b1, 32'h5);
        inv = (out_port == 4'h6) ? 1 : 0;
        for (int i = 0; i < PC + 3; i++) begin
            cycle(2'd3, 1'b0, 32'h0);
            if (out_port == 4'h6) inv++;
        end
        check("t3_pulse_len", 32'(inv), 32'(PC));
        check("t3_after", {28'h0, out_port}, 32'h3);
        cycle(2'd3, 1'b0, 32'h0);
        check("t3_idle_stat", readdata, 32'h0);

        // 4: retrigger moves the inversion, zero mask cancels
        cycle(2'd3, 1'b1, 32'h1);
        cycle(2'd2, 1'b0, 32'h0);
        cycle(2'd2, 1'b0, 32'h0);
        cycle(2'd3, 1'b1, 32'h2);
        check("t4_retrig", {28'h0, out_port}, 32'h1);
        for (int i = 0; i < PC + 2; i++) cycle(2'd3, 1'b0, 32'h0);
        cycle(2'd3, 1'b1, 32'h4);
        cycle(2'd1, 1'b0, 32'h0);
        cycle(2'd3, 1'b1, 32'h0);
        check("t4_cancel", {28'h0, out_port}, 32'h3);

        // 5: DATA write during an active pulse
        cycle(2'd3, 1'b1, 32'h3);
        cycle(2'd0, 1'b1, 32'hF);
        check("t5_during", {28'h0, out_port}, 32'hC);
        for (int i = 0; i < PC; i++) cycle(2'd1, 1'b0, 32'h0);
        check("t5_after", {28'h0, out_port}, 32'hF);

        // 6: asynchronous reset mid-pulse
        cycle(2'd3, 1'b1, 32'h6);
        cycle(2'd3, 1'b0, 32'h0);
        #2 reset_n = 1'b0;
        #1;
        check("t6_out", {28'h0, out_port}, 32'h0);
        check("t6_rd", readdata, 32'h0);
        check("t6_cnt", 32'(dut.u_timer.count), 32'h0);
        @(posedge clk);
        #3 reset_n = 1'b1;
        m_data = 4'h0;
        m_mask = 4'h0;
        m_cnt  = 0;
        for (int i = 0; i < PC + 2; i++) cycle(2'(i), 1'b0, 32'h0);
        check("t6_no_glitch", {28'h0, out_port}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
